// File: rtl/main_dec_pipe.sv
// MIPS main decoder: combinational D-stage decode plus the E/M/W control
// pipeline, bubble/flush insertion and the multi-cycle MULT/DIV occupancy stall.
module main_dec_pipe #(
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr_d,
   input  logic        valid_d,
   input  logic        stall_in,
   input  logic        flush_e,
   output logic [9:0]  ctrl_d,
   output logic        invalid_d,
   output logic        stall_d,
   output logic [9:0]  ctrl_e,
   output logic [9:0]  ctrl_m,
   output logic [9:0]  ctrl_w,
   output logic        valid_e,
   output logic        valid_m,
   output logic        valid_w,
   output logic        md_busy
);

   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

   // Bundle order: regwrite regdst alusrc branch memwrite memtoreg jump al_regdst md_kind[1:0]
   localparam logic [9:0] B_RALU   = 10'b11_0000_00_00;
   localparam logic [9:0] B_MULT   = 10'b00_0000_00_01;
   localparam logic [9:0] B_DIV    = 10'b00_0000_00_10;
   localparam logic [9:0] B_IALU   = 10'b10_1000_00_00;
   localparam logic [9:0] B_LW     = 10'b10_1001_00_00;
   localparam logic [9:0] B_SW     = 10'b00_1010_00_00;
   localparam logic [9:0] B_BR     = 10'b00_0100_00_00;
   localparam logic [9:0] B_BRAL   = 10'b10_0100_01_00;
   localparam logic [9:0] B_J      = 10'b00_0000_10_00;
   localparam logic [9:0] B_JAL    = 10'b10_0000_11_00;

   localparam logic [1:0] MD_MUL = 2'b01;
   localparam logic [1:0] MD_DIV = 2'b10;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_ADDI   = 6'b001000;
   localparam logic [5:0] OP_ADDIU  = 6'b001001;
   localparam logic [5:0] OP_SLTI   = 6'b001010;
   localparam logic [5:0] OP_SLTIU  = 6'b001011;
   localparam logic [5:0] OP_ANDI   = 6'b001100;
   localparam logic [5:0] OP_ORI    = 6'b001101;
   localparam logic [5:0] OP_XORI   = 6'b001110;
   localparam logic [5:0] OP_LUI    = 6'b001111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;

   localparam logic [5:0] F_SLL   = 6'b000000;
   localparam logic [5:0] F_SRL   = 6'b000010;
   localparam logic [5:0] F_SRA   = 6'b000011;
   localparam logic [5:0] F_SLLV  = 6'b000100;
   localparam logic [5:0] F_SRLV  = 6'b000110;
   localparam logic [5:0] F_SRAV  = 6'b000111;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_XOR   = 6'b100110;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_SLTU  = 6'b101011;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   logic [5:0]       op;
   logic [5:0]       funct;
   logic [4:0]       rt;
   logic [9:0]       dec;
   logic             unsup;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_load;
   logic             unused_fields;

   assign op    = instr_d[31:26];
   assign rt    = instr_d[20:16];
   assign funct = instr_d[5:0];

   // rs, rd, shamt and immediate bits carry no control information here
   assign unused_fields = ^{instr_d[25:21], instr_d[15:6]};

   always_comb begin
      dec   = '0;
      unsup = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
               F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
               F_SLT, F_SLTU, F_MFHI, F_MFLO: dec = B_RALU;
               F_MULT, F_MULTU:               dec = B_MULT;
               F_DIV, F_DIVU:                 dec = B_DIV;
               F_MTHI, F_MTLO:                dec = '0;
               default:                       unsup = 1'b1;
            endcase
         end
         OP_REGIMM: begin
            case (rt)
               RT_BLTZ, RT_BGEZ:     dec = B_BR;
               RT_BLTZAL, RT_BGEZAL: dec = B_BRAL;
               default:              unsup = 1'b1;
            endcase
         end
         OP_J:                                        dec = B_J;
         OP_JAL:                                      dec = B_JAL;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:            dec = B_BR;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI:            dec = B_IALU;
         OP_LW:                                       dec = B_LW;
         OP_SW:                                       dec = B_SW;
         default:                                     unsup = 1'b1;
      endcase
   end

   assign ctrl_d    = valid_d ? dec : '0;
   assign invalid_d = valid_d & unsup;

   assign md_busy = (cnt != '0);
   assign stall_d = stall_in | md_busy;

   // Remaining occupancy beyond the first E cycle; latency 1 loads zero.
   always_comb begin
      cnt_load = '0;
      if (ctrl_d[1:0] == MD_MUL)
         cnt_load = MUL_LOAD;
      else if (ctrl_d[1:0] == MD_DIV)
         cnt_load = DIV_LOAD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_e  <= '0;
         valid_e <= 1'b0;
         cnt     <= '0;
      end else if (flush_e) begin
         ctrl_e  <= '0;
         valid_e <= 1'b0;
         cnt     <= '0;
      end else if (md_busy) begin
         cnt <= cnt - 1'b1;
      end else if (stall_in) begin
         ctrl_e  <= '0;
         valid_e <= 1'b0;
      end else begin
         ctrl_e  <= ctrl_d;
         valid_e <= valid_d;
         cnt     <= cnt_load;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_m  <= '0;
         valid_m <= 1'b0;
         ctrl_w  <= '0;
         valid_w <= 1'b0;
      end else begin
         if (md_busy) begin
            ctrl_m  <= '0;
            valid_m <= 1'b0;
         end else begin
            ctrl_m  <= ctrl_e;
            valid_m <= valid_e;
         end
         ctrl_w  <= ctrl_m;
         valid_w <= valid_m;
      end
   end

endmodule
